// File: rtl/doc_hw_pkg_hw.sv
// Shared types and constants for the DOC dual-rail health monitor.
// Imported by the channel FSM, the monitor top level and the bench.
package doc_hw_pkg_hw;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_GOOD,
        ST_PEND,
        ST_FAULT
    } mon_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_DISC    = 2'b01,
        CAUSE_BAD     = 2'b10,
        CAUSE_STARTUP = 2'b11
    } fault_cause_t;

    typedef enum logic [1:0] {
        KIND_GOOD,
        KIND_BAD,
        KIND_DISC
    } sample_kind_t;

    localparam int CH_PWR  = 0;
    localparam int CH_TEMP = 1;
    localparam int CH_CRAM = 2;

    // (1,0) is healthy, (0,1) is an explicit bad report, equal rails are discrepant.
    function automatic sample_kind_t classify(input logic p, input logic n);
        if (p && !n) return KIND_GOOD;
        if (!p && n) return KIND_BAD;
        return KIND_DISC;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/doc_rail_channel.sv
// One monitored dual-rail pair: startup timeout, debounce/discrepancy
// run counting and a latched fault that only an explicit clear releases.
module doc_rail_channel
    import doc_hw_pkg_hw::*;
#(
    parameter int P_DISC_CYCLES    = 4,
    parameter int P_DEBOUNCE       = 8,
    parameter int P_STARTUP_CYCLES = 1024,
    parameter int P_CNT_W          = 11
) (
    input  logic         hw_clk,
    input  logic         hw_reset,
    input  sample_kind_t kind_i,
    input  logic         clear_fault_i,
    output mon_state_t   state_o,
    output logic         fault_latched_o,
    output fault_cause_t fault_cause_o
);

    localparam logic [P_CNT_W-1:0] CNT_ONE   = P_CNT_W'(1);
    localparam logic [P_CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [P_CNT_W-1:0] DISC_C    = P_CNT_W'(P_DISC_CYCLES);
    localparam logic [P_CNT_W-1:0] DEB_C     = P_CNT_W'(P_DEBOUNCE);
    localparam logic [P_CNT_W-1:0] STARTUP_C = P_CNT_W'(P_STARTUP_CYCLES);

    mon_state_t          state_q, state_d;
    fault_cause_t        cause_q, cause_d;
    sample_kind_t        kind_q, kind_d;
    logic [P_CNT_W-1:0]  cnt_q, cnt_d;
    logic [P_CNT_W-1:0]  cnt_inc;
    logic [P_CNT_W-1:0]  run_len;
    logic [P_CNT_W-1:0]  thr;
    fault_cause_t        kind_cause;

    always_ff @(posedge hw_clk or posedge hw_reset) begin
        if (hw_reset) begin
            state_q <= ST_INIT;
            cause_q <= CAUSE_NONE;
            kind_q  <= KIND_GOOD;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            cause_q <= cause_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d    = state_q;
        cause_d    = cause_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        thr        = (kind_i == KIND_BAD) ? DEB_C : DISC_C;
        kind_cause = (kind_i == KIND_BAD) ? CAUSE_BAD : CAUSE_DISC;
        run_len    = CNT_ONE;

        unique case (state_q)
            ST_INIT: begin
                if (kind_i == KIND_GOOD) begin
                    state_d = ST_GOOD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == STARTUP_C) begin
                        state_d = ST_FAULT;
                        cause_d = CAUSE_STARTUP;
                    end
                end
            end
            ST_GOOD, ST_PEND: begin
                if (kind_i == KIND_GOOD) begin
                    state_d = ST_GOOD;
                    cnt_d   = '0;
                end else begin
                    // A kind change restarts the run at one, as does leaving GOOD.
                    if (state_q == ST_PEND && kind_i == kind_q) begin
                        run_len = cnt_inc;
                    end
                    kind_d = kind_i;
                    cnt_d  = run_len;
                    if (run_len == thr) begin
                        state_d = ST_FAULT;
                        cause_d = kind_cause;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
            end
            ST_FAULT: begin
                if (clear_fault_i && kind_i == KIND_GOOD) begin
                    state_d = ST_GOOD;
                    cause_d = CAUSE_NONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign state_o         = state_q;
    assign fault_latched_o = (state_q == ST_FAULT);
    assign fault_cause_o   = cause_q;

endmodule

// File: rtl/doc_rail_monitor.sv
// DOC rail monitor top: input register, per-channel FSMs and the
// registered aggregate dual-rail sys_ok pair for the safety controller.
module doc_rail_monitor
    import doc_hw_pkg_hw::*;
#(
    parameter int P_NO_MON         = 3,
    parameter int P_DISC_CYCLES    = 4,
    parameter int P_DEBOUNCE       = 8,
    parameter int P_STARTUP_CYCLES = 1024
) (
    input  logic                  hw_clk,
    input  logic                  hw_reset,
    input  logic [P_NO_MON-1:0]   mon_p,
    input  logic [P_NO_MON-1:0]   mon_n,
    input  logic                  clear_fault,
    output logic                  sys_ok_p,
    output logic                  sys_ok_n,
    output logic [P_NO_MON-1:0]   fault_latched,
    output logic [2*P_NO_MON-1:0] fault_cause
);

    localparam int CNT_W = $clog2(max3(P_STARTUP_CYCLES, P_DEBOUNCE, P_DISC_CYCLES) + 1);

    logic [P_NO_MON-1:0] r_p_q, r_n_q;
    logic                sys_ok_q, sys_ok_d;
    sample_kind_t        kind   [P_NO_MON];
    mon_state_t          ch_state [P_NO_MON];

    always_ff @(posedge hw_clk or posedge hw_reset) begin
        if (hw_reset) begin
            r_p_q    <= '0;
            r_n_q    <= '0;
            sys_ok_q <= 1'b0;
        end else begin
            r_p_q    <= mon_p;
            r_n_q    <= mon_n;
            sys_ok_q <= sys_ok_d;
        end
    end

    always_comb begin
        for (int i = 0; i < P_NO_MON; i++) begin
            kind[i] = classify(r_p_q[i], r_n_q[i]);
        end
    end

    for (genvar i = 0; i < P_NO_MON; i++) begin : g_ch
        doc_rail_channel #(
            .P_DISC_CYCLES    (P_DISC_CYCLES),
            .P_DEBOUNCE       (P_DEBOUNCE),
            .P_STARTUP_CYCLES (P_STARTUP_CYCLES),
            .P_CNT_W          (CNT_W)
        ) u_ch (
            .hw_clk          (hw_clk),
            .hw_reset        (hw_reset),
            .kind_i          (kind[i]),
            .clear_fault_i   (clear_fault),
            .state_o         (ch_state[i]),
            .fault_latched_o (fault_latched[i]),
            .fault_cause_o   (fault_cause[2*i +: 2])
        );
    end

    // PEND still counts as healthy: a short glitch must not drop sys_ok.
    always_comb begin
        sys_ok_d = 1'b1;
        for (int i = 0; i < P_NO_MON; i++) begin
            if (ch_state[i] == ST_INIT || ch_state[i] == ST_FAULT) begin
                sys_ok_d = 1'b0;
            end
        end
    end

    assign sys_ok_p = sys_ok_q;
    assign sys_ok_n = ~sys_ok_q;

endmodule

// File: doc/doc_rail_monitor.md
# doc_rail_monitor

Downstream safety checker for the DOC hardware subsystem. It consumes the registered dual-rail health pairs (power, temperature, CRAM) produced by the DOC hardware block. Each pair is classified as good, bad or discrepant, with a per-channel debounce, discrepancy tolerance and startup timeout. Faults are latched until an explicit clear, and one aggregate dual-rail `sys_ok` pair goes to the safety controller.

## Interface
Parameters:
- `P_NO_MON`, 3: number of monitored dual-rail pairs. Bit 0 = pwr, 1 = temp, 2 = cram.
- `P_DISC_CYCLES`, 4: consecutive discrepant samples (p==n) tolerated before fault. Minimum 1.
- `P_DEBOUNCE`, 8: consecutive bad samples (p=0, n=1) before fault. Minimum 1.
- `P_STARTUP_CYCLES`, 1024: samples allowed after reset for the first good sample. Minimum 1.

Ports:
- `hw_clk` in 1: single clock.
- `hw_reset` in 1: reset, asynchronous, active-high.
- `mon_p` in `P_NO_MON`: positive rails, synchronous to `hw_clk`.
- `mon_n` in `P_NO_MON`: negative rails.
- `clear_fault` in 1: level; requests the return of faulted channels to service.
- `sys_ok_p` out 1: aggregate health, positive rail.
- `sys_ok_n` out 1: aggregate health, negative rail. Always equals `~sys_ok_p`.
- `fault_latched` out `P_NO_MON`: per-channel fault flag.
- `fault_cause` out `2*P_NO_MON`: per-channel code in bits [2i+1:2i]. 00 none, 01 discrepancy, 10 debounced bad, 11 startup timeout.

## Operation
- Input stage: `mon_p`/`mon_n` are registered once into `r_p`/`r_n`. Classification of each channel:
  - GOOD = (1,0)
  - BAD = (0,1)
  - DISC = (0,0) or (1,1)
- Each channel has its own FSM (INIT, GOOD, PEND, FAULT) and a saturating counter `cnt`. The counter is sized to `$clog2(max(P_STARTUP_CYCLES, P_DEBOUNCE, P_DISC_CYCLES)+1)`.
- INIT (reset state; `cnt` = 0):
  - GOOD → GOOD.
  - Otherwise `cnt`++. If the new `cnt` equals `P_STARTUP_CYCLES` → FAULT with cause 11.
- GOOD:
  - GOOD → stay.
  - BAD or DISC → PEND, with `cnt` = 1 and the sample kind recorded.
  - If the threshold for that kind is 1, go straight to FAULT instead.
- PEND:
  - GOOD → GOOD, `cnt` = 0.
  - Same kind as recorded → `cnt`++. If it reaches `P_DEBOUNCE` (BAD) or `P_DISC_CYCLES` (DISC) → FAULT with cause 10 or 01 respectively.
  - Kind change (BAD↔DISC) → `cnt` = 1, new kind recorded, count restarts.
- FAULT:
  - Held with the cause latched; `fault_latched[i]` = 1.
  - `clear_fault` = 1 together with a GOOD sample → GOOD, cause 00, `fault_latched[i]` = 0.
  - `clear_fault` with a non-GOOD sample is ignored.
- Aggregate:
  - `sys_ok_p` is registered. It is 1 when every channel is in GOOD or PEND.
  - Any INIT or FAULT channel forces `sys_ok_p` = 0.
- Simultaneous events:
  - Channels are fully independent.
  - `clear_fault` only affects channels in FAULT; it has no effect on INIT, GOOD or PEND.
  - If a channel enters FAULT in the same cycle that `clear_fault` is high, the fault is kept (the clear is evaluated only in the FAULT state).
- Reset asserted mid-operation: all state returns immediately (asynchronously) to reset values, and the startup timeout restarts.

## Timing
- Reset values:
  - `r_p`/`r_n` = 0
  - all FSMs in INIT, `cnt` = 0
  - `sys_ok_p` = 0, `sys_ok_n` = 1
  - `fault_latched` = 0, `fault_cause` = 0
- Latency: a pin change before edge k is registered at edge k, moves the FSM at edge k+1, and changes `sys_ok` at edge k+2.
- A discrepancy first registered at edge k causes FAULT at edge k+`P_DISC_CYCLES`, and `sys_ok_p` falls at edge k+`P_DISC_CYCLES`+1.
- A bad condition follows the same pattern with `P_DEBOUNCE`.
- A good sample registered at edge k after a clear gives GOOD at k+1 and `sys_ok_p` = 1 at k+2, provided all other channels are healthy.
- Counters saturate and never wrap.

## Structure
- `doc_hw_pkg_hw` holds:
  - `mon_state_t` enum (INIT, GOOD, PEND, FAULT)
  - `fault_cause_t` enum (NONE, DISC, BAD, STARTUP)
  - sample-kind enum
  - the channel index constants for pwr, temp and cram.
- Sub-module `doc_rail_channel`: one-channel FSM plus counter, instanced `P_NO_MON` times in a generate loop. The top level holds the input register and the aggregate register.

## Test plan
Bench uses `P_STARTUP_CYCLES`=16, `P_DEBOUNCE`=8, `P_DISC_CYCLES`=4.
- Reset, all pairs (1,0) → `sys_ok_p`=1 at the 3rd edge after reset release; `fault_latched`=000.
- Pwr pair (1,1) for 3 cycles then (1,0) → no fault, `sys_ok_p` stays 1. Pwr pair (1,1) for 4 cycles → `fault_cause`[1:0]=01, `sys_ok_p`=0 one edge later.
- Temp pair (0,1) for 7 cycles, then 1 cycle (0,0), then (0,1) for 7 cycles → no fault (kind change restarts count). 8 consecutive (0,1) → cause[3:2]=10.
- Cram pair held (0,0) from reset → FAULT at the 16th sample, cause[5:4]=11, `sys_ok_p` never rises.
- Pwr faulted, `clear_fault`=1 while pair is (1,1) → still faulted. Pair restored to (1,0) with `clear_fault`=1 → `fault_latched[0]`=0, `sys_ok_p`=1 two edges later.
- `hw_reset` asserted mid-PEND and mid-FAULT → outputs are at reset values in the same cycle; the startup timeout restarts from 0.
